// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer feeding the Pwm register bank: keeps a current and a target
// duty per channel and, on every rate tick, walks each unsettled channel one
// LSB toward its target, issuing each new duty as a one-cycle write strobe.
module pwm_fade_sequencer #(
  parameter int unsigned Resolution   = 8,
  parameter int unsigned AddressWidth = 2,
  parameter int unsigned RateWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tgt_we,
  input  logic [AddressWidth-1:0] tgt_addr,
  input  logic [Resolution-1:0]   tgt_data,
  input  logic                    rate_we,
  input  logic [RateWidth-1:0]    rate_data,
  output logic                    pwm_ce,
  output logic [AddressWidth-1:0] pwm_addr,
  output logic [Resolution-1:0]   pwm_data,
  output logic                    busy,
  output logic                    settled
);

  localparam int unsigned N = 2 ** AddressWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [AddressWidth-1:0] idx, idx_next;
  logic                    pending, pending_next;

  logic [Resolution-1:0]   current [N];
  logic [Resolution-1:0]   target  [N];
  logic [RateWidth-1:0]    rate;
  logic [RateWidth-1:0]    divider;

  logic                    tick_c;
  logic                    last_c;
  logic                    advance_c;
  logic                    cur_we_c;
  logic [Resolution-1:0]   cur_new_c;
  logic                    ce_next;
  logic [AddressWidth-1:0] addr_next;
  logic [Resolution-1:0]   data_next;

  assign tick_c = (divider == rate);
  assign last_c = (idx == AddressWidth'(N - 1));

  // Rate register and free-running tick divider; a rate write restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate    <= '1;
      divider <= '0;
    end else begin
      if (rate_we) begin
        rate <= rate_data;
      end
      if (rate_we || tick_c) begin
        divider <= '0;
      end else begin
        divider <= divider + RateWidth'(1);
      end
    end
  end

  // Target duties, writable by software at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        target[i] <= '0;
      end
    end else if (tgt_we) begin
      target[tgt_addr] <= tgt_data;
    end
  end

  // Current duties, stepped by the scan FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        current[i] <= '0;
      end
    end else if (cur_we_c) begin
      current[idx] <= cur_new_c;
    end
  end

  // FSM state, pending tick, and registered Pwm write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      pwm_ce   <= 1'b0;
      pwm_addr <= '0;
      pwm_data <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      pending  <= pending_next;
      busy     <= (state_next != IDLE);
      pwm_ce   <= ce_next;
      pwm_addr <= addr_next;
      pwm_data <= data_next;
    end
  end

  // Scan next-state: one channel per CHECK, one-cycle WRITE for each step taken.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    pending_next = pending;
    advance_c    = 1'b0;
    cur_we_c     = 1'b0;
    cur_new_c    = current[idx];
    ce_next      = 1'b0;
    addr_next    = pwm_addr;
    data_next    = pwm_data;

    case (state)
      IDLE: begin
        if (tick_c || pending) begin
          state_next   = CHECK;
          idx_next     = '0;
          pending_next = 1'b0;
        end
      end
      CHECK: begin
        if (current[idx] != target[idx]) begin
          cur_we_c     = 1'b1;
          cur_new_c    = (target[idx] > current[idx]) ?
                         current[idx] + Resolution'(1) :
                         current[idx] - Resolution'(1);
          ce_next      = 1'b1;
          addr_next    = idx;
          data_next    = cur_new_c;
          state_next   = WRITE;
          pending_next = pending || tick_c;
        end else begin
          advance_c = 1'b1;
        end
      end
      WRITE: begin
        advance_c = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Move to the next channel; at the end of a scan restart at once if a tick is due,
    // so back-to-back scans never pass through IDLE.
    if (advance_c) begin
      if (last_c) begin
        idx_next = '0;
        if (pending || tick_c) begin
          state_next   = CHECK;
          pending_next = pending && tick_c;
        end else begin
          state_next   = IDLE;
        end
      end else begin
        state_next   = CHECK;
        idx_next     = idx + AddressWidth'(1);
        pending_next = pending || tick_c;
      end
    end
  end

  // All channels at target.
  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (current[i] != target[i]) begin
        settled = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: stimulus pushes expected Pwm writes,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_we;
  logic [1:0] tgt_addr;
  logic [7:0] tgt_data;
  logic       rate_we;
  logic [15:0] rate_data;
  logic       pwm_ce;
  logic [1:0] pwm_addr;
  logic [7:0] pwm_data;
  logic       busy;
  logic       settled;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr  = -1;
  int gap_lo   = 0;
  int gap_hi   = 0;
  logic [9:0] exp_q [$];

  pwm_fade_sequencer dut (
    .clk(clk), .rst(rst),
    .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_data(tgt_data),
    .rate_we(rate_we), .rate_data(rate_data),
    .pwm_ce(pwm_ce), .pwm_addr(pwm_addr), .pwm_data(pwm_data),
    .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && pwm_ce) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", pwm_addr, pwm_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({pwm_addr, pwm_data} != e) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                   pwm_addr, pwm_data, e[9:8], e[7:0]);
        end
      end
      if (gap_lo != 0 && last_wr >= 0) begin
        n_checks++;
        if (cyc - last_wr < gap_lo || cyc - last_wr > gap_hi) begin
          n_fail++;
          $display("FAIL write_gap: got %0d expected %0d..%0d", cyc - last_wr, gap_lo, gap_hi);
        end
      end
      last_wr = cyc;
    end
  end

  task automatic push(input int a, input int d);
    exp_q.push_back({2'(a), 8'(d)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tgt_we = 1'b0; tgt_addr = '0; tgt_data = '0;
    rate_we = 1'b0; rate_data = '0;
    exp_q.delete();
    last_wr = -1; gap_lo = 0; gap_hi = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_tgt(input int a, input int d);
    tgt_we = 1'b1; tgt_addr = 2'(a); tgt_data = 8'(d);
    @(negedge clk);
    tgt_we = 1'b0;
  endtask

  task automatic set_rate(input int r);
    rate_we = 1'b1; rate_data = 16'(r);
    @(negedge clk);
    rate_we = 1'b0;
  endtask

  // Wait until every expected write has been seen and all channels are settled.
  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && settled) break;
    end
    if (k == budget) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_%s: got %0d writes outstanding expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int drops;
    bit seen;
    int k;

    // 1 reset and quiet period
    rst = 1'b1;
    tgt_we = 1'b0; tgt_addr = '0; tgt_data = '0;
    rate_we = 1'b0; rate_data = '0;
    #12;
    chk("rst_pwm_ce", int'(pwm_ce), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_settled", int'(settled), 1);
    chk("rst_addr", int'(pwm_addr), 0);
    chk("rst_data", int'(pwm_data), 0);
    do_reset();
    repeat (50) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // 2 fade up ch0 to 5 at rate 3: one write per tick at most
    do_reset();
    for (int i = 1; i <= 5; i++) push(0, i);
    gap_lo = 4; gap_hi = 8;
    set_tgt(0, 5);
    chk("fade_unsettled", int'(settled), 0);
    set_rate(3);
    wait_done("fade", 200);
    chk("fade_settled", int'(settled), 1);
    chk("fade_cur_data", int'(pwm_data), 5);
    repeat (40) @(negedge clk);
    gap_lo = 0;

    // 3 multi-channel at rate 0
    do_reset();
    for (int s = 1; s <= 255; s++) begin
      if (s <= 3) push(0, s);
      push(2, s);
      if (s <= 2) push(3, s);
    end
    set_tgt(0, 3); set_tgt(1, 0); set_tgt(2, 255); set_tgt(3, 2);
    set_rate(0);
    wait_done("multi", 4000);
    chk("multi_q_empty", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("multi_last_data", int'(pwm_data), 255);

    // 4 reversal on ch1 at current 10
    do_reset();
    for (int i = 1; i <= 10; i++) push(1, i);
    for (int i = 9; i >= 4; i--) push(1, i);
    set_tgt(1, 200);
    set_rate(0);
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (pwm_ce && pwm_addr == 2'd1 && pwm_data == 8'd10) break;
    end
    if (k == 500) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_rev10: got no write of 10 expected one");
    end
    set_tgt(1, 4);
    wait_done("rev", 500);
    repeat (20) @(negedge clk);
    chk("rev_q_empty", exp_q.size(), 0);

    // 5 back-to-back scans with pending ticks
    do_reset();
    for (int s = 1; s <= 3; s++) for (int c = 0; c < 4; c++) push(c, s);
    set_tgt(0, 3); set_tgt(1, 3); set_tgt(2, 3); set_tgt(3, 3);
    rate_we = 1'b1; rate_data = 16'd0;
    @(negedge clk);
    rate_we = 1'b0;
    seen = 0; drops = 0;
    for (k = 0; k < 300; k++) begin
      if (busy) seen = 1;
      else if (seen) drops++;
      if (exp_q.size() == 0 && settled) break;
      @(negedge clk);
    end
    if (k == 300) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_pend: got %0d writes outstanding expected 0", exp_q.size());
    end
    chk("pend_busy_seen", int'(seen), 1);
    chk("pend_busy_drops", drops, 0);

    // 6 reset during a WRITE cycle
    do_reset();
    push(0, 1);
    set_tgt(0, 50);
    set_rate(0);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pwm_ce) break;
    end
    if (k == 50) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_rstwr: got no write expected one");
    end
    #2 rst = 1'b1;
    #1;
    chk("rstmid_pwm_ce", int'(pwm_ce), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_settled", int'(settled), 1);
    chk("rstmid_data", int'(pwm_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("post_rst_settled", int'(settled), 1);
    chk("post_rst_busy", int'(busy), 0);
    push(0, 1);
    set_tgt(0, 1);
    set_rate(0);
    wait_done("post_rst", 100);
    repeat (10) @(negedge clk);
    chk("post_rst_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
